// File: rtl/pc_unit.sv
// Program counter with sequential, jump, relative-branch and call/return
// sequencing backed by a small return-address stack; state moves on falling CLK.
module pc_unit #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned RST_VAL     = 0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] TARGET,
  input  logic [WIDTH-1:0] OFFSET,
  output logic [WIDTH-1:0] COUNT,
  output logic             STACK_EMPTY,
  output logic             STACK_FULL,
  output logic             ERR
);

  localparam int unsigned OCC_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RST_VAL);
  localparam logic [OCC_W-1:0] DEPTH_W = OCC_W'(STACK_DEPTH);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] seq_addr;
  logic             err_next;
  logic             push;

  // Return address and fall-through target share the same wrapped increment.
  assign seq_addr = COUNT + STEP_W;

  // Next-state selection; rejected CALL/RET fall through to a plain increment.
  always_comb begin
    count_next = seq_addr;
    occ_next   = occ;
    err_next   = 1'b0;
    push       = 1'b0;
    if (STALL) begin
      count_next = COUNT;
    end else begin
      case (OP)
        OP_INC:    count_next = seq_addr;
        OP_JUMP:   count_next = TARGET;
        OP_BRANCH: count_next = COUNT + OFFSET;
        OP_CALL: begin
          if (occ == DEPTH_W) begin
            err_next = 1'b1;
          end else begin
            push       = 1'b1;
            occ_next   = occ + OCC_W'(1);
            count_next = TARGET;
          end
        end
        OP_RET: begin
          if (occ == '0) begin
            err_next = 1'b1;
          end else begin
            occ_next   = occ - OCC_W'(1);
            count_next = stack_mem[IDX_W'(occ_next)];
          end
        end
        default:   count_next = seq_addr;
      endcase
    end
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      COUNT       <= RST_W;
      occ         <= '0;
      STACK_EMPTY <= 1'b1;
      STACK_FULL  <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      COUNT       <= count_next;
      occ         <= occ_next;
      STACK_EMPTY <= (occ_next == '0);
      STACK_FULL  <= (occ_next == DEPTH_W);
      ERR         <= err_next;
    end
  end

  // Stack storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(negedge CLK) begin
    if (push && !RESET) begin
      stack_mem[IDX_W'(occ)] <= seq_addr;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: the driver queues expected outputs,
// a monitor compares them on the rising edge or right after an async reset.
module tb_pc_unit;

  localparam logic [2:0] INC  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] BR   = 3'b010;
  localparam logic [2:0] CALL = 3'b011;
  localparam logic [2:0] RET  = 3'b100;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       STALL = 1'b0;
  logic [2:0] OP = 3'b000;
  logic [7:0] TARGET = 8'h00;
  logic [7:0] OFFSET = 8'h00;
  logic [7:0] COUNT;
  logic       STACK_EMPTY;
  logic       STACK_FULL;
  logic       ERR;

  typedef logic [10:0] obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  event  chk_ev;

  pc_unit #(.WIDTH(8), .STEP(1), .RST_VAL(0), .STACK_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .OP(OP),
    .TARGET(TARGET), .OFFSET(OFFSET), .COUNT(COUNT),
    .STACK_EMPTY(STACK_EMPTY), .STACK_FULL(STACK_FULL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic expect_now(input string nm, input logic [7:0] c,
                            input logic e, input logic f, input logic r);
    exp_q.push_back({c, e, f, r});
    name_q.push_back(nm);
  endtask

  // Called in the high phase; applies inputs across one falling edge.
  task automatic step(input string nm, input logic [2:0] op, input logic [7:0] tgt,
                      input logic [7:0] off, input logic stall, input logic rst,
                      input logic [7:0] c, input logic e, input logic f, input logic r);
    OP = op; TARGET = tgt; OFFSET = off; STALL = stall; RESET = rst;
    @(negedge CLK);
    expect_now(nm, c, e, f, r);
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse in the high phase, checked before any falling edge.
  task automatic pulse_reset(input string nm);
    RESET = 1'b1;
    #1;
    expect_now(nm, 8'h00, 1'b1, 1'b0, 1'b0);
    -> chk_ev;
    #1;
    RESET = 1'b0;
  endtask

  initial begin : monitor
    obs_t  want;
    obs_t  got;
    string nm;
    forever begin
      @(posedge CLK or chk_ev);
      while (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {COUNT, STACK_EMPTY, STACK_FULL, ERR};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL %s: got count=%h empty=%b full=%b err=%b, want count=%h empty=%b full=%b err=%b",
                   nm, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    @(posedge CLK);
    #1;
    pulse_reset("rst_init");
    step("inc1",      INC,  8'h00, 8'h00, 0, 0, 8'h01, 1, 0, 0);
    step("inc2",      INC,  8'h00, 8'h00, 0, 0, 8'h02, 1, 0, 0);
    step("inc3",      INC,  8'h00, 8'h00, 0, 0, 8'h03, 1, 0, 0);
    step("jump_fe",   JMP,  8'hFE, 8'h00, 0, 0, 8'hFE, 1, 0, 0);
    step("inc_ff",    INC,  8'h00, 8'h00, 0, 0, 8'hFF, 1, 0, 0);
    step("inc_wrap",  INC,  8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    step("jump_10",   JMP,  8'h10, 8'h00, 0, 0, 8'h10, 1, 0, 0);
    step("br_neg",    BR,   8'h00, 8'hFC, 0, 0, 8'h0C, 1, 0, 0);
    step("br_pos",    BR,   8'h00, 8'h05, 0, 0, 8'h11, 1, 0, 0);
    step("jump_05",   JMP,  8'h05, 8'h00, 0, 0, 8'h05, 1, 0, 0);
    step("call_40",   CALL, 8'h40, 8'h00, 0, 0, 8'h40, 0, 0, 0);
    step("call_80",   CALL, 8'h80, 8'h00, 0, 0, 8'h80, 0, 0, 0);
    step("ret_41",    RET,  8'h00, 8'h00, 0, 0, 8'h41, 0, 0, 0);
    step("ret_06",    RET,  8'h00, 8'h00, 0, 0, 8'h06, 1, 0, 0);
    step("jump_ff",   JMP,  8'hFF, 8'h00, 0, 0, 8'hFF, 1, 0, 0);
    step("call_wrap", CALL, 8'h20, 8'h00, 0, 0, 8'h20, 0, 0, 0);
    step("ret_wrap",  RET,  8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    step("call_a0",   CALL, 8'hA0, 8'h00, 0, 0, 8'hA0, 0, 0, 0);
    step("call_a1",   CALL, 8'hA1, 8'h00, 0, 0, 8'hA1, 0, 0, 0);
    step("call_a2",   CALL, 8'hA2, 8'h00, 0, 0, 8'hA2, 0, 0, 0);
    step("call_full", CALL, 8'hA3, 8'h00, 0, 0, 8'hA3, 0, 1, 0);
    step("call_ovf",  CALL, 8'h90, 8'h00, 0, 0, 8'hA4, 0, 1, 1);
    step("err_clr",   INC,  8'h00, 8'h00, 0, 0, 8'hA5, 0, 1, 0);
    step("ret_top",   RET,  8'h00, 8'h00, 0, 0, 8'hA3, 0, 0, 0);
    pulse_reset("rst_mid");
    step("ret_udf",   RET,  8'h00, 8'h00, 0, 0, 8'h01, 1, 0, 1);
    step("udf_clr",   INC,  8'h00, 8'h00, 0, 0, 8'h02, 1, 0, 0);
    step("ret_udf2",  RET,  8'h00, 8'h00, 0, 0, 8'h03, 1, 0, 1);
    step("stall1",    JMP,  8'h33, 8'h00, 1, 0, 8'h03, 1, 0, 0);
    step("stall2",    JMP,  8'h33, 8'h00, 1, 0, 8'h03, 1, 0, 0);
    pulse_reset("rst_stall");
    step("rst_hold",  JMP,  8'h33, 8'h00, 1, 1, 8'h00, 1, 0, 0);
    step("jump_33",   JMP,  8'h33, 8'h00, 0, 0, 8'h33, 1, 0, 0);
    step("call_50",   CALL, 8'h50, 8'h00, 0, 0, 8'h50, 0, 0, 0);
    step("stall_call",CALL, 8'h60, 8'h00, 1, 0, 8'h50, 0, 0, 0);
    step("ret_34",    RET,  8'h00, 8'h00, 0, 0, 8'h34, 1, 0, 0);
    step("br_wrap",   BR,   8'h00, 8'hD0, 0, 0, 8'h04, 1, 0, 0);
    step("op_101",    3'b101, 8'h77, 8'h00, 0, 0, 8'h05, 1, 0, 0);
    step("op_111",    3'b111, 8'h77, 8'h00, 0, 0, 8'h06, 1, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      miscompares += exp_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
